atx_uart: RTL and testbench
===========================

# atx_uart

UART transmitter that serialises bytes written by the FETCH processor program over its `atx_data`/`atx_load`/`atx_busy` output-word interface. It sits directly downstream of the program ROM's I/O writes: the program loads `atx_data`, raises `atx_load`, waits for `atx_busy`, then drops `atx_load`. The block emits 8N1 (optionally 8N2) frames on `txd` at a parameterised bit period.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit. Legal range is ≥ 2. 434 gives 115200 baud at 50 MHz.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`  in  1  system clock. Single clock domain; all logic is on the rising edge.
- `reset_n`  in  1  reset. Asynchronous assert, active-low.
- `atx_data`  in  8  byte to send. Sampled only at frame capture.
- `atx_load`  in  1  level from the processor. A rising edge requests a frame.
- `atx_busy`  out  1  high from capture until the last stop bit ends.
- `txd`  out  1  serial line. Idles high.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - STOP
- Edge detect: register `load_q` holds `atx_load` each cycle. A capture occurs when `atx_load & ~load_q` in IDLE.
- `load_q` resets to 1. An `atx_load` held high through reset release does not start a frame.
- On capture:
  - Latch `atx_data` into an 8-bit shift register.
  - Clear the bit counter (3 bits) and the baud counter (width `$clog2(CLKS_PER_BIT)`).
  - Enter START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then enter DATA.
- DATA:
  - `txd` = shift[0]. Bits go out LSB first.
  - At each bit-period end, shift right and increment the bit counter.
  - After bit 7, enter STOP.
- STOP: `txd`=1 for `STOP_BITS*CLKS_PER_BIT` cycles, then enter IDLE.
- `atx_busy` = (state != IDLE).
- Bit-period end is `baud_cnt == CLKS_PER_BIT-1`; the counter then returns to 0. No fractional baud.
- `txd` is driven from a register, so there are no combinational glitches on the pin.

## Timing
- Reset values: state IDLE, `txd`=1, `atx_busy`=0, `load_q`=1, all counters 0, shift register 0.
- Rising edge of `atx_load` sampled at edge N in IDLE: from edge N+1, `atx_busy`=1 and `txd`=0.
- Frame length is exactly `(9+STOP_BITS)*CLKS_PER_BIT` cycles from edge N+1.
- `atx_busy` falls on the same edge that ends the final stop-bit cycle. `txd` stays 1 from then on.
- Back-to-back frames: a new rising edge may be accepted on the first IDLE cycle. The minimum gap between frames is 0 bit periods after the stop bit(s).
- Boundary behaviour:
  - Rising edge of `atx_load` while busy: ignored, with no queueing. `load_q` still tracks, so a level that stays high after busy falls does not retrigger.
  - `atx_load` toggling 1→0→1 while busy: ignored.
  - Changes to `atx_data` after capture have no effect on the frame in progress.
  - Reset asserted mid-frame: `txd`=1 and `atx_busy`=0 immediately (asynchronously). The frame is aborted with no partial resumption.
  - `atx_load` rising and reset deasserting in the same cycle: no capture, because `load_q`=1.

## Test plan
- CLKS_PER_BIT=4, STOP_BITS=1, send 0x55 → `txd` per 4-cycle slot is 0,1,0,1,0,1,0,1,0,1. `atx_busy` is high for exactly 40 cycles, starting the cycle after the load edge.
- Send 0x80, then 0x01 with the load edge on the first IDLE cycle → two contiguous 40-cycle frames. `txd` slots are 0,0000000 1,1 then 0,1 0000000,1. `atx_busy` has no low gap longer than the 1-cycle edge-detect latency.
- Hold `atx_load`=1 for 100 cycles after one edge, with `atx_data` changed to 0xFF mid-frame → exactly one frame of the original byte. No second frame starts.
- STOP_BITS=2, send 0x00 → `txd` low for 36 cycles, then high for 8. `atx_busy` is high for 44 cycles.
- Assert `reset_n`=0 during data bit 3 → `txd`=1 and `atx_busy`=0 within the same cycle. After release with `atx_load` held high, no frame is sent.
- Replay the ROM-style handshake (load=0, set data, load=1, poll busy, load=0, poll idle) for 6 bytes 0x55,0xAA,0x55,0xAA,0x44,0x00 → a UART monitor decodes the same 6 bytes in order with no framing errors.

Source files
------------

// File: rtl/atx_uart.sv
// ============================================================================
//  Module   : atx_uart
//  Purpose  : Byte-serialising UART transmitter (8N1/8N2) driven by a
//             level-style load handshake from the FETCH processor.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module atx_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] atx_data,
    input  logic       atx_load,
    output logic       atx_busy,
    output logic       txd
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                load_q, load_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic                txd_q, txd_d;
    logic                bit_end;

    // load_q resets high so a load level held through reset release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            load_q     <= 1'b1;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            txd_q      <= txd_d;
        end
    end

    assign bit_end = (baud_cnt_q == BAUD_LAST);

    // txd_d is computed for the state being entered so the pin changes on
    // the same edge as the state register.
    always_comb begin
        state_d    = state_q;
        load_d     = atx_load;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = bit_end ? '0 : (baud_cnt_q + BAUD_ONE);
        txd_d      = txd_q;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                txd_d      = 1'b1;
                if (atx_load && !load_q) begin
                    state_d   = START;
                    shift_d   = atx_data;
                    bit_cnt_d = 3'd0;
                    txd_d     = 1'b0;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = STOP;
                        bit_cnt_d = 3'd0;
                        txd_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign atx_busy = (state_q != IDLE);
    assign txd      = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_atx_uart.sv
// ============================================================================
//  Module   : tb_atx_uart
//  Purpose  : Directed self-checking bench for atx_uart (CLKS_PER_BIT=4,
//             one instance with 1 stop bit and one with 2 stop bits).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atx_uart;

    logic       clk;
    logic       reset_n;
    logic [7:0] data1, data2;
    logic       load1, load2;
    logic       busy1, busy2;
    logic       txd1, txd2;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic       w_busy, w_txd;
    assign w_busy = (sel == 1) ? busy2 : busy1;
    assign w_txd  = (sel == 1) ? txd2  : txd1;

    atx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .atx_data (data1),
        .atx_load (load1),
        .atx_busy (busy1),
        .txd      (txd1)
    );

    atx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .atx_data (data2),
        .atx_load (load2),
        .atx_busy (busy2),
        .txd      (txd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sits just after the capture edge; slot k of the frame covers
    // cycles 4k..4k+3, cycles past the frame must be idle.
    task automatic check_frame(input string tag, input logic [11:0] slots,
                               input int nslots, input int total);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c < nslots * 4) begin
                chk({tag, " busy"}, 32'(w_busy), 32'd1);
                chk({tag, " txd"},  32'(w_txd),  32'(slots[c / 4]));
            end else begin
                chk({tag, " idle busy"}, 32'(w_busy), 32'd0);
                chk({tag, " idle txd"},  32'(w_txd),  32'd1);
            end
        end
    endtask

    // Line monitor on dut1: samples mid-bit, counts bad start/stop bits.
    logic       mon_en   = 1'b0;
    logic       mon_act  = 1'b0;
    int         mon_cnt  = 0;
    int         mon_ferr = 0;
    logic [7:0] mon_sh   = 8'h00;
    logic [7:0] mon_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!mon_act) begin
                    if (txd1 === 1'b0) begin
                        mon_act = 1'b1;
                        mon_cnt = 0;
                    end
                end else begin
                    mon_cnt++;
                    if (mon_cnt == 2 && txd1 !== 1'b0) mon_ferr++;
                    if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
                        mon_sh = {txd1, mon_sh[7:1]};
                    if (mon_cnt == 38) begin
                        if (txd1 !== 1'b1) mon_ferr++;
                        mon_q.push_back(mon_sh);
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [7:0] hs_bytes [6] = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h44, 8'h00};

    initial begin
        reset_n = 1'b0;
        data1 = 8'h00; load1 = 1'b0;
        data2 = 8'h00; load2 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset txd1",  32'(txd1),  32'd1);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset txd2",  32'(txd2),  32'd1);
        chk("reset busy2", 32'(busy2), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // 0x55, 8N1
        data1 = 8'h55; load1 = 1'b1;
        @(posedge clk); #1 load1 = 1'b0;
        check_frame("f55", 12'b1010101010, 10, 41);

        // 0x80 then 0x01 loaded on the first idle cycle
        @(posedge clk); #1;
        data1 = 8'h80; load1 = 1'b1;
        @(posedge clk); #1 load1 = 1'b0;
        check_frame("f80", 12'b1100000000, 10, 40);
        @(posedge clk); #1;
        chk("b2b gap busy", 32'(busy1), 32'd0);
        data1 = 8'h01; load1 = 1'b1;
        @(posedge clk); #1 load1 = 1'b0;
        check_frame("f01", 12'b1000000010, 10, 41);

        // Load held high, data changed and load toggled mid-frame
        @(posedge clk); #1;
        data1 = 8'h33; load1 = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 10) data1 = 8'hFF;
            if (c == 20) load1 = 1'b0;
            if (c == 22) load1 = 1'b1;
            if (c < 40) begin
                chk("hold busy", 32'(busy1), 32'd1);
                chk("hold txd",  32'(txd1),  32'(c < 4 ? 1'b0 : (c >= 36 ? 1'b1 : data1_ref(c / 4 - 1))));
            end else begin
                chk("hold no retrigger busy", 32'(busy1), 32'd0);
                chk("hold no retrigger txd",  32'(txd1),  32'd1);
            end
        end
        load1 = 1'b0;

        // 0x00 with two stop bits
        sel = 1;
        @(posedge clk); #1;
        data2 = 8'h00; load2 = 1'b1;
        @(posedge clk); #1 load2 = 1'b0;
        check_frame("f00 2stop", 12'b11000000000, 11, 46);
        sel = 0;

        // Reset during data bit 3, load held high through release
        @(posedge clk); #1;
        data1 = 8'h00; load1 = 1'b1;
        @(posedge clk); #1 load1 = 1'b0;
        check_frame("abort", 12'b1000000000, 10, 18);
        load1 = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("abort txd",  32'(txd1),  32'd1);
        chk("abort busy", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("post-reset busy", 32'(busy1), 32'd0);
            chk("post-reset txd",  32'(txd1),  32'd1);
        end
        load1 = 1'b0;

        // Processor-style handshake decoded by the line monitor
        @(posedge clk); #1;
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load1 = 1'b0;
            @(posedge clk); #1;
            data1 = hs_bytes[i];
            @(posedge clk); #1;
            load1 = 1'b1;
            for (int k = 0; k < 10 && busy1 !== 1'b1; k++) @(negedge clk);
            chk("hs busy rise", 32'(busy1), 32'd1);
            load1 = 1'b0;
            for (int k = 0; k < 60 && busy1 !== 1'b0; k++) @(negedge clk);
            chk("hs busy fall", 32'(busy1), 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("hs frame count", 32'(mon_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < mon_q.size())
                chk("hs byte", 32'(mon_q[i]), 32'(hs_bytes[i]));
        end
        chk("hs framing errors", 32'(mon_ferr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bits of the original 0x33 captured byte (data changes after capture must not show).
    function automatic logic data1_ref(input int bit_idx);
        logic [7:0] b;
        b = 8'h33;
        return b[bit_idx];
    endfunction

endmodule

`default_nettype wire
